// File: rtl/axis_seq_checker_if.sv
// AXI-stream sink bundle for axis_seq_checker.
// aclken qualifies every beat together with tvalid/tready.
interface axis_seq_checker_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             aclken;
  logic             tready;

  modport master (
    output tdata, tvalid, tlast, aclken,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, aclken,
    output tready
  );
endinterface

// File: rtl/axis_seq_checker.sv
// Stream sink: checks data sequence and frame length, counts frames/errors.
// Optional AXIS_CHECK_BACKPRESSURE_EN adds LFSR-driven random tready.
module axis_seq_checker #(
  parameter int    DSIZE      = 8,
  parameter string MODE       = "RANGE",
  parameter int    LED_FRAMES = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] expected_length,
  axis_seq_checker_if.slave s_axis,
  output logic        data_err,
  output logic        len_err,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt,
  output logic        led
);

  localparam bit         IS_RANGE = (MODE == "RANGE");
  localparam logic [7:0] LED_N    = 8'(LED_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] exp_q, exp_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             bad_q, bad_d;
  logic [7:0]       good_q, good_d;
  logic             led_q, led_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             derr_q, derr_d;
  logic             lerr_q, lerr_d;

  logic        bp;
  logic        tready;
  logic        beat;
  logic        len_on;
  logic [15:0] cnt_inc;
  logic [16:0] err_sum;

`ifdef AXIS_CHECK_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clock) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign bp = lfsr_q[0];
`else
  assign bp = 1'b1;
`endif

  assign tready        = (state_q != IDLE) & bp;
  assign s_axis.tready = tready;
  assign beat    = s_axis.tvalid & tready & s_axis.aclken;
  assign len_on  = (expected_length != 16'd0);
  assign cnt_inc = cnt_q + 16'd1;

  // FSM only moves on enabled stream cycles
  always_comb begin
    state_d = state_q;
    if (s_axis.aclken) begin
      unique case (state_q)
        IDLE: if (enable) state_d = RUN;
        RUN: begin
          if (!enable)
            state_d = (beat && s_axis.tlast) ? IDLE : DRAIN;
        end
        DRAIN: if (beat && s_axis.tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    bad_d       = bad_q;
    good_d      = good_q;
    led_d       = led_q;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    derr_d      = 1'b0;
    lerr_d      = 1'b0;
    err_sum     = '0;
    if (beat) begin
      derr_d = (s_axis.tdata != exp_q);
      exp_d  = IS_RANGE ? s_axis.tdata + DSIZE'(1) : '0;
      if (len_on) begin
        if (s_axis.tlast) begin
          lerr_d = !ovr_q && (cnt_inc != expected_length);
        end else if (!ovr_q && cnt_inc == expected_length) begin
          lerr_d = 1'b1;
          ovr_d  = 1'b1;
        end
      end
      err_sum   = {1'b0, err_cnt_q} + 17'(derr_d) + 17'(lerr_d);
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (s_axis.tlast) begin
        cnt_d       = '0;
        ovr_d       = 1'b0;
        bad_d       = 1'b0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (bad_q | derr_d | lerr_d) begin
          good_d = '0;
        end else if (good_q + 8'd1 == LED_N) begin
          good_d = '0;
          led_d  = ~led_q;
        end else begin
          good_d = good_q + 8'd1;
        end
      end else begin
        cnt_d = cnt_inc;
        bad_d = bad_q | derr_d | lerr_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      bad_q       <= 1'b0;
      good_q      <= '0;
      led_q       <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
      derr_q      <= 1'b0;
      lerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
      led_q       <= led_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      derr_q      <= derr_d;
      lerr_q      <= lerr_d;
    end
  end

  assign data_err  = derr_q;
  assign len_err   = lerr_q;
  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign led       = led_q;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed bench for axis_seq_checker: vector table plus
// hand-written LED, drain, clock-enable and reset sequences.
module tb_axis_seq_checker;

  logic        clock;
  logic        rst;
  logic        enable;
  logic [15:0] expected_length;
  logic        data_err;
  logic        len_err;
  logic [15:0] err_cnt;
  logic [15:0] frame_cnt;
  logic        led;

  int pass_n;
  int total_n;
  logic [7:0] d;

  axis_seq_checker_if #(.DSIZE(8)) sif ();

  axis_seq_checker #(
    .DSIZE     (8),
    .MODE      ("RANGE"),
    .LED_FRAMES(16)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .enable         (enable),
    .expected_length(expected_length),
    .s_axis         (sif.slave),
    .data_err       (data_err),
    .len_err        (len_err),
    .err_cnt        (err_cnt),
    .frame_cnt      (frame_cnt),
    .led            (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rst_first;
    logic [15:0] len;
    logic [7:0]  d;
    bit          l;
    bit          derr;
    bit          lerr;
    logic [15:0] err;
    logic [15:0] frm;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input bit r, input logic [15:0] len,
                   input logic [7:0] dd, input bit l,
                   input bit de, input bit le,
                   input logic [15:0] e, input logic [15:0] f);
    vec_t x;
    x.rst_first = r;
    x.len = len;
    x.d = dd;
    x.l = l;
    x.derr = de;
    x.lerr = le;
    x.err = e;
    x.frm = f;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] req);
    total_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    enable = 1'b0;
    sif.tvalid = 1'b0;
    sif.tlast = 1'b0;
    sif.aclken = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_beat(input logic [7:0] dd, input logic l);
    @(negedge clock);
    sif.tdata = dd;
    sif.tvalid = 1'b1;
    sif.tlast = l;
    @(posedge clock);
    #1;
    sif.tvalid = 1'b0;
    sif.tlast = 1'b0;
  endtask

  task automatic clean_frame();
    for (int k = 0; k < 4; k++) begin
      do_beat(d, k == 3);
      d = d + 8'd1;
    end
  endtask

  initial begin
    pass_n = 0;
    total_n = 0;
    rst = 1'b1;
    enable = 1'b0;
    expected_length = 16'd4;
    sif.tdata = '0;
    sif.tvalid = 1'b0;
    sif.tlast = 1'b0;
    sif.aclken = 1'b1;
    @(posedge clock);
    #1;
    chk("reset_outs", {sif.tready, data_err, len_err, led, err_cnt, frame_cnt}, '0);

    // 1: clean 3 frames
    for (int i = 0; i < 12; i++)
      v(i == 0, 4, 8'(i), (i % 4) == 3, 0, 0, 0, 16'((i + 1) / 4));
    // 2: one corrupted beat, resync costs a second error
    for (int i = 0; i < 12; i++)
      v(i == 0, 4, (i == 5) ? 8'h20 : 8'(i), (i % 4) == 3,
        (i == 5) || (i == 6), 0,
        (i < 5) ? 16'd0 : (i == 5) ? 16'd1 : 16'd2, 16'((i + 1) / 4));
    // 3: short frame then clean frame
    v(1, 4, 0, 0, 0, 0, 0, 0);
    v(0, 4, 1, 0, 0, 0, 0, 0);
    v(0, 4, 2, 1, 0, 1, 1, 1);
    v(0, 4, 3, 0, 0, 0, 1, 1);
    v(0, 4, 4, 0, 0, 0, 1, 1);
    v(0, 4, 5, 0, 0, 0, 1, 1);
    v(0, 4, 6, 1, 0, 0, 1, 2);
    // 4: overrun flagged once at beat 4
    for (int i = 0; i < 6; i++)
      v(i == 0, 4, 8'(i), i == 5, 0, i == 3, (i >= 3) ? 16'd1 : 16'd0,
        (i == 5) ? 16'd1 : 16'd0);
    // data and length error on the same beat count twice
    v(1, 4, 0, 0, 0, 0, 0, 0);
    v(0, 4, 1, 0, 0, 0, 0, 0);
    v(0, 4, 9, 1, 1, 1, 2, 1);
    // expected data wraps FF -> 00
    v(1, 4, 8'hFE, 0, 1, 0, 1, 0);
    v(0, 4, 8'hFF, 0, 0, 0, 1, 0);
    v(0, 4, 8'h00, 0, 0, 0, 1, 0);
    v(0, 4, 8'h01, 1, 0, 0, 1, 1);
    // length 0 disables the length check
    v(1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0);
    v(0, 0, 2, 1, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      expected_length = tbl[i].len;
      do_beat(tbl[i].d, tbl[i].l);
      chk($sformatf("vec%0d", i),
          {data_err, len_err, err_cnt, frame_cnt},
          {tbl[i].derr, tbl[i].lerr, tbl[i].err, tbl[i].frm});
    end

    // 5: LED heartbeat
    do_reset();
    expected_length = 16'd4;
    d = 8'd0;
    for (int f = 0; f < 15; f++) clean_frame();
    chk("led_after15", {33'd0, led}, 34'd0);
    clean_frame();
    chk("led_after16", {33'd0, led}, 34'd1);
    do_beat(d, 1'b0);
    do_beat(d + 8'd1, 1'b0);
    do_beat(d + 8'd2, 1'b1);
    d = d + 8'd3;
    chk("led_badframe", {len_err, led, err_cnt}, {1'b1, 1'b1, 16'd1});
    for (int f = 0; f < 15; f++) clean_frame();
    chk("led_bad_plus15", {33'd0, led}, 34'd1);
    clean_frame();
    chk("led_toggle_back", {led, err_cnt, frame_cnt}, {1'b0, 16'd1, 16'd33});

    // 6: enable drop mid-frame drains to tlast; aclken stalls
    do_reset();
    chk("rdy_run", {33'd0, sif.tready}, 34'd1);
    do_beat(8'd0, 1'b0);
    do_beat(8'd1, 1'b0);
    enable = 1'b0;
    do_beat(8'd2, 1'b0);
    chk("rdy_drain", {33'd0, sif.tready}, 34'd1);
    @(negedge clock);
    sif.aclken = 1'b0;
    sif.tvalid = 1'b1;
    sif.tdata = 8'h55;
    sif.tlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("aclken_hold%0d", c),
          {sif.tready, data_err, len_err, err_cnt, frame_cnt},
          {1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
    end
    sif.aclken = 1'b1;
    sif.tvalid = 1'b0;
    sif.tlast = 1'b0;
    do_beat(8'd3, 1'b1);
    chk("drain_end", {sif.tready, data_err, len_err, err_cnt, frame_cnt},
        {1'b0, 1'b0, 1'b0, 16'd0, 16'd1});
    repeat (2) @(posedge clock);
    #1;
    chk("idle_stays", {33'd0, sif.tready}, 34'd0);

    // enable falling on a tlast beat goes straight to IDLE
    do_reset();
    do_beat(8'd0, 1'b0);
    do_beat(8'd1, 1'b0);
    do_beat(8'd2, 1'b0);
    enable = 1'b0;
    do_beat(8'd3, 1'b1);
    chk("tlast_drop", {sif.tready, err_cnt, frame_cnt},
        {1'b0, 16'd0, 16'd1});

    // reset mid-frame discards the partial frame
    do_reset();
    do_beat(8'd0, 1'b0);
    do_beat(8'd1, 1'b0);
    do_reset();
    chk("midrst", {err_cnt, frame_cnt}, '0);
    for (int i = 0; i < 4; i++) do_beat(8'(i), i == 3);
    chk("midrst_next", {data_err, len_err, err_cnt, frame_cnt},
        {1'b0, 1'b0, 16'd0, 16'd1});

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
